// File: rtl/bf16_to_q10_8_stream.sv
// BF16 -> signed Q10.8 streaming converter.
// Two-stage valid/ready pipeline with saturation and sticky status.
module bf16_to_q10_8_stream #(
  parameter int FRAC_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_bf16,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [17:0]      out_q,
  output logic             out_sat,
  output logic             nan_seen,
  output logic [CNT_W-1:0] sat_count,
  input  logic             clr_stat
);

  // Value scaled to Q.FRAC_BITS is sig * 2^(exp - bias).
  localparam logic signed [9:0] SHIFT_BIAS =
    10'(134 - FRAC_BITS);
  localparam logic [17:0] Q_MAX = 18'h1FFFF;
  localparam logic [17:0] Q_MIN = 18'h20000;
  localparam logic [18:0] MAG_POS = 19'd131071;
  localparam logic [18:0] MAG_NEG = 19'd131072;

  typedef struct packed {
    logic              sign;
    logic              nan;
    logic              inf;
    logic              zero;
    logic [7:0]        sig;
    logic signed [9:0] shift;
  } dec_t;

  dec_t        dec_c;
  dec_t        s1;
  logic        s1_v;
  logic        s2_v;
  logic        adv2;
  logic        acc_in;
  logic        out_fire;
  logic [7:0]  exp_f;
  logic [6:0]  man_f;
  logic        ovf;
  logic [2:0]  nsh;
  logic [18:0] mag;
  logic [17:0] q_c;
  logic        sat_c;

  assign exp_f     = in_bf16[14:7];
  assign man_f     = in_bf16[6:0];
  assign adv2      = !s2_v || out_ready;
  assign in_ready  = !s1_v || adv2;
  assign acc_in    = in_valid && in_ready;
  assign out_valid = s2_v;
  assign out_fire  = s2_v && out_ready;

  // Stage 1 decode: split fields and classify the operand.
  always_comb begin
    dec_c       = '0;
    dec_c.sign  = in_bf16[15];
    dec_c.nan   = (exp_f == 8'hFF) && (man_f != 7'd0);
    dec_c.inf   = (exp_f == 8'hFF) && (man_f == 7'd0);
    dec_c.zero  = (exp_f == 8'h00);
    dec_c.sig   = {1'b1, man_f};
    dec_c.shift = $signed({2'b00, exp_f}) - SHIFT_BIAS;
  end

  // Stage 2 align: shift the significand, truncating toward zero.
  always_comb begin
    ovf = 1'b0;
    mag = '0;
    nsh = 3'd0 - s1.shift[2:0];
    if (s1.shift >= 10'sd11) begin
      ovf = 1'b1;
    end else if (s1.shift >= 10'sd0) begin
      mag = {11'd0, s1.sig} << s1.shift[3:0];
    end else if (s1.shift > -10'sd8) begin
      mag = {11'd0, s1.sig} >> nsh;
    end
  end

  // Stage 2 clamp: pick result and saturation flag per class.
  always_comb begin
    q_c   = '0;
    sat_c = 1'b0;
    unique case (1'b1)
      s1.nan: begin
        q_c = '0;
      end
      s1.zero: begin
        q_c = '0;
      end
      s1.inf: begin
        sat_c = 1'b1;
        q_c   = s1.sign ? Q_MIN : Q_MAX;
      end
      default: begin
        if (!s1.sign) begin
          if (ovf || mag > MAG_POS) begin
            sat_c = 1'b1;
            q_c   = Q_MAX;
          end else begin
            q_c = mag[17:0];
          end
        end else begin
          if (ovf || mag > MAG_NEG) begin
            sat_c = 1'b1;
            q_c   = Q_MIN;
          end else begin
            q_c = ~mag[17:0] + 18'd1;
          end
        end
      end
    endcase
  end

  // Pipeline registers; s2 holds while stalled downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1      <= '0;
      out_q   <= '0;
      out_sat <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) s1 <= dec_c;
      end
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_q   <= q_c;
          out_sat <= sat_c;
        end
      end
    end
  end

  // Sticky status; a same-cycle event beats clr_stat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nan_seen  <= 1'b0;
      sat_count <= '0;
    end else begin
      if (acc_in && dec_c.nan) begin
        nan_seen <= 1'b1;
      end else if (clr_stat) begin
        nan_seen <= 1'b0;
      end
      if (out_fire && out_sat) begin
        if (clr_stat) begin
          sat_count <= CNT_W'(1);
        end else if (sat_count != '1) begin
          sat_count <= sat_count + CNT_W'(1);
        end
      end else if (clr_stat) begin
        sat_count <= '0;
      end
    end
  end

endmodule
